// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus_mem_target memory-backed bus target.
package bus_pkg;

  typedef enum logic [1:0] {
    MODE_RD  = 2'b00,
    MODE_WR  = 2'b01,
    MODE_BRD = 2'b10,
    MODE_BWR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WAIT  = 2'b10,
    XFER  = 2'b11
  } state_t;

  localparam int BURST_LEN_DEF = 4;

  function automatic logic is_write(input mode_t m);
    return (m == MODE_WR) || (m == MODE_BWR);
  endfunction

  function automatic logic is_burst(input mode_t m);
    return (m == MODE_BRD) || (m == MODE_BWR);
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Single-port memory: synchronous write, registered read; contents are never reset.
module bus_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register holds the last read value until the next read beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_target.sv
// Bus target answering req/start with gnt/rdy, backed by a 2**ADDR_W x DATA_W memory.
// Optional per-beat access counters are enabled with `define BUS_ACCESS_COUNT_EN.
module bus_mem_target
  import bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              gnt,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
`ifdef BUS_ACCESS_COUNT_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int                BEAT_W      = $clog2(BURST_LEN + 1);
  localparam logic [3:0]        WAIT_LOAD   = 4'(WAIT_CYCLES);
  localparam logic [BEAT_W-1:0] BEATS_BURST = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEATS_ONE   = BEAT_W'(1);
  localparam state_t            BEAT_ENTRY  = (WAIT_CYCLES == 0) ? XFER : WAIT;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [3:0]        wait_q, wait_d;
  logic              gnt_q, gnt_d, busy_q, busy_d, rdy_q, rdy_d;
  logic              wr_pend_q, wr_pend_d;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_RD;
      addr_q    <= '0;
      wr_addr_q <= '0;
      beat_q    <= '0;
      wait_q    <= 4'd0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      wr_addr_q <= addr_q;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Next-state and transfer bookkeeping.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (req) state_d = GRANT;
        else     state_d = IDLE;
      end
      GRANT: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          addr_d  = addr;
          beat_d  = is_burst(mode_t'(mode)) ? BEATS_BURST : BEATS_ONE;
          wait_d  = WAIT_LOAD;
          state_d = BEAT_ENTRY;
        end else if (!req) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = XFER;
        else                state_d = WAIT;
      end
      XFER: begin
        addr_d = addr_q + ADDR_W'(1);
        beat_d = beat_q - BEATS_ONE;
        if (beat_q > BEATS_ONE) begin
          wait_d  = WAIT_LOAD;
          state_d = BEAT_ENTRY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The beat completes at the end of its XFER cycle; write data is taken in the following rdy cycle.
  always_comb begin
    gnt_d     = (state_d != IDLE);
    busy_d    = (state_d == WAIT) || (state_d == XFER);
    rdy_d     = (state_q == XFER);
    wr_pend_d = (state_q == XFER) && is_write(mode_q);
    mem_re    = (state_q == XFER) && !is_write(mode_q);
    mem_we    = wr_pend_q && !rst;
    mem_addr  = wr_pend_q ? wr_addr_q : addr_q;
  end

  bus_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign rdy  = rdy_q;

`ifdef BUS_ACCESS_COUNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Saturating per-beat access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      if (mem_re && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_pend_d && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_bus_mem_target.sv
// Randomized self-checking bench for bus_mem_target against a byte-array reference model.
module tb_bus_mem_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic       gnt, rdy, busy;
  logic [7:0] rdata;
  logic       z_req = 1'b0, z_start = 1'b0;
  logic [1:0] z_mode = 2'b00;
  logic [7:0] z_addr = 8'h00, z_wdata = 8'h00;
  logic       z_gnt, z_rdy, z_busy;
  logic [7:0] z_rdata;
`ifdef BUS_ACCESS_COUNT_EN
  logic [15:0] rd_count, wr_count, z_rd_count, z_wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_mem [2][256];
  bit         ref_val [2][256];
  int         exp_rd [2];
  int         exp_wr [2];

  always #5 clk = ~clk;

  bus_mem_target #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .start(start), .mode(mode), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rdy(rdy), .rdata(rdata), .busy(busy)
`ifdef BUS_ACCESS_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  bus_mem_target #(.WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .req(z_req), .start(z_start), .mode(z_mode), .addr(z_addr),
    .wdata(z_wdata), .gnt(z_gnt), .rdy(z_rdy), .rdata(z_rdata), .busy(z_busy)
`ifdef BUS_ACCESS_COUNT_EN
    , .rd_count(z_rd_count), .wr_count(z_wr_count)
`endif
  );

  task automatic set_in(input bit z, input logic r, input logic s, input logic [1:0] m, input logic [7:0] a);
    if (z) begin z_req = r; z_start = s; z_mode = m; z_addr = a; end
    else   begin req = r;   start = s;   mode = m;   addr = a;   end
  endtask

  task automatic set_wd(input bit z, input logic [7:0] d);
    if (z) z_wdata = d;
    else   wdata = d;
  endtask

  // {gnt, rdy, busy, rdata}
  function automatic logic [10:0] obs(input bit z);
    return z ? {z_gnt, z_rdy, z_busy, z_rdata} : {gnt, rdy, busy, rdata};
  endfunction

  function automatic void model_wr(input bit z, input logic [7:0] a, input logic [31:0] wb, input int nb);
    for (int i = 0; i < nb; i++) begin
      logic [7:0] ad;
      ad = a + 8'(i);
      ref_mem[z][ad] = wb[8*i +: 8];
      ref_val[z][ad] = 1'b1;
    end
    exp_wr[z] += nb;
  endfunction

  // Runs one transaction; expected beat timing comes from rdy at (beat+1)*(W+1) cycles after start.
  task automatic do_xfer(input bit z, input logic [1:0] m, input logic [7:0] a, input logic [31:0] wb,
                         output logic [31:0] rb, output int n_rdy, output int bad_t, output int gnt_lat);
    int w, nb, last_c;
    logic [10:0] o;
    logic exp_r;
    w = z ? 0 : 2;
    nb = m[1] ? 4 : 1;
    last_c = nb * (w + 1);
    rb = '0; n_rdy = 0; bad_t = 0; gnt_lat = -1;
    set_in(z, 1'b1, 1'b0, m, a);
    set_wd(z, wb[7:0]);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      o = obs(z);
      if (o[10] === 1'b1) begin gnt_lat = i; break; end
    end
    if (gnt_lat < 0) begin
      set_in(z, 1'b0, 1'b0, m, a);
      return;
    end
    set_in(z, 1'b1, 1'b1, m, a);
    for (int c = 0; c <= last_c + 2; c++) begin
      @(negedge clk);
      if (c == 0) set_in(z, 1'b0, 1'b0, m, a);
      if (n_rdy < 4) set_wd(z, wb[8*n_rdy +: 8]);
      o = obs(z);
      exp_r = (n_rdy < nb) && (c == (n_rdy + 1) * (w + 1));
      if (o[9] !== exp_r) bad_t++;
      if ((o[10] !== (c < last_c)) || (o[8] !== (c < last_c))) bad_t++;
      if (o[9] === 1'b1 && n_rdy < 4) begin
        rb[8*n_rdy +: 8] = o[7:0];
        n_rdy++;
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int z = 0; z < 2; z++) begin
      o = obs(z[0]);
      n_checks++;
      if (o[10] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt dut%0d: got %b want 0", z, o[10]); end
      n_checks++;
      if (o[9] !== 1'b0) begin n_fail++; $display("FAIL reset_rdy dut%0d: got %b want 0", z, o[9]); end
      n_checks++;
      if (o[8] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", z, o[8]); end
      n_checks++;
      if (o[7:0] !== 8'h00) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h want 00", z, o[7:0]); end
    end
    rst = 1'b0;
    exp_rd = '{0, 0};
    exp_wr = '{0, 0};
  endtask

  task automatic test_single();
    logic [31:0] rb; int n, bt, gl;
    do_xfer(1'b0, 2'b01, 8'h10, 32'h0000_00A5, rb, n, bt, gl);
    model_wr(1'b0, 8'h10, 32'h0000_00A5, 1);
    n_checks++;
    if (gl != 1) begin n_fail++; $display("FAIL single_gnt_latency: got %0d want 1", gl); end
    n_checks++;
    if (bt != 0 || n != 1) begin n_fail++; $display("FAIL single_write_timing: errs %0d beats %0d want 0/1", bt, n); end
    do_xfer(1'b0, 2'b00, 8'h10, 32'h0, rb, n, bt, gl);
    exp_rd[0] += 1;
    n_checks++;
    if (bt != 0 || n != 1) begin n_fail++; $display("FAIL single_read_timing: errs %0d beats %0d want 0/1", bt, n); end
    n_checks++;
    if (rb[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_read_data: got %h want a5", rb[7:0]); end
    do_xfer(1'b0, 2'b01, 8'h20, 32'h0000_003C, rb, n, bt, gl);
    model_wr(1'b0, 8'h20, 32'h0000_003C, 1);
    n_checks++;
    if (rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold_after_write: got %h want a5", rdata); end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] rb; int n, bt, gl;
    do_xfer(1'b0, 2'b11, 8'hFE, 32'h4433_2211, rb, n, bt, gl);
    model_wr(1'b0, 8'hFE, 32'h4433_2211, 4);
    n_checks++;
    if (bt != 0 || n != 4) begin n_fail++; $display("FAIL wrap_write_timing: errs %0d beats %0d want 0/4", bt, n); end
    do_xfer(1'b0, 2'b10, 8'hFE, 32'h0, rb, n, bt, gl);
    exp_rd[0] += 4;
    n_checks++;
    if (bt != 0 || n != 4) begin n_fail++; $display("FAIL wrap_read_timing: errs %0d beats %0d want 0/4", bt, n); end
    n_checks++;
    if (rb !== 32'h4433_2211) begin n_fail++; $display("FAIL wrap_read_data: got %h want 44332211", rb); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rb, wb; int n, bt, gl, nr;
    logic [10:0] o;
    do_xfer(1'b0, 2'b11, 8'h40, 32'h0D0C_0B0A, rb, n, bt, gl);
    model_wr(1'b0, 8'h40, 32'h0D0C_0B0A, 4);
    wb = 32'hE4E3_E2E1;
    set_in(1'b0, 1'b1, 1'b0, 2'b11, 8'h40);
    set_wd(1'b0, wb[7:0]);
    gl = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin gl = i; break; end
    end
    n_checks++;
    if (gl != 1) begin n_fail++; $display("FAIL abort_gnt_latency: got %0d want 1", gl); end
    set_in(1'b0, 1'b1, 1'b1, 2'b11, 8'h40);
    nr = 0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b0, 1'b0, 1'b0, 2'b11, 8'h40);
      if (nr < 4) set_wd(1'b0, wb[8*nr +: 8]);
      o = obs(1'b0);
      if (c == 5) begin
        n_checks++;
        if (o !== 11'h000 || nr != 1) begin
          n_fail++; $display("FAIL abort_outputs: got %h beats %0d want 000/1", o, nr);
        end
      end
      if (o[9] === 1'b1) nr++;
      if (c == 4) rst = 1'b1;
    end
    rst = 1'b0;
    ref_mem[0][8'h40] = 8'hE1;
    ref_val[0][8'h41] = 1'b0;
    exp_rd = '{0, 0};
    exp_wr = '{0, 0};
    do_xfer(1'b0, 2'b10, 8'h40, 32'h0, rb, n, bt, gl);
    exp_rd[0] += 4;
    n_checks++;
    if (bt != 0 || n != 4) begin n_fail++; $display("FAIL abort_read_timing: errs %0d beats %0d", bt, n); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ad;
      ad = 8'h40 + 8'(i);
      if (ref_val[0][ad]) begin
        n_checks++;
        if (rb[8*i +: 8] !== ref_mem[0][ad]) begin
          n_fail++; $display("FAIL abort_mem[%h]: got %h want %h", ad, rb[8*i +: 8], ref_mem[0][ad]);
        end
      end
    end
  endtask

  task automatic test_req_no_start();
    logic [31:0] rb; int n, bt, gl, g_hi, r_hi;
    g_hi = 0; r_hi = 0;
    set_in(1'b0, 1'b1, 1'b0, 2'b01, 8'h10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) g_hi++;
      if (rdy === 1'b1) r_hi++;
      if (i == 0) set_in(1'b0, 1'b0, 1'b0, 2'b01, 8'h10);
    end
    n_checks++;
    if (g_hi != 1 || r_hi != 0) begin n_fail++; $display("FAIL req_pulse: gnt cycles %0d rdy %0d want 1/0", g_hi, r_hi); end
    do_xfer(1'b0, 2'b00, 8'h10, 32'h0, rb, n, bt, gl);
    exp_rd[0] += 1;
    n_checks++;
    if (rb[7:0] !== ref_mem[0][8'h10]) begin n_fail++; $display("FAIL req_pulse_mem: got %h want %h", rb[7:0], ref_mem[0][8'h10]); end
  endtask

  task automatic test_start_no_gnt();
    logic [31:0] rb; int n, bt, gl, hits;
    hits = 0;
    set_in(1'b0, 1'b0, 1'b1, 2'b01, 8'h10);
    set_wd(1'b0, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt === 1'b1 || rdy === 1'b1 || busy === 1'b1) hits++;
    end
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    n_checks++;
    if (hits != 0) begin n_fail++; $display("FAIL start_no_gnt_outputs: active cycles %0d want 0", hits); end
    do_xfer(1'b0, 2'b00, 8'h10, 32'h0, rb, n, bt, gl);
    exp_rd[0] += 1;
    n_checks++;
    if (rb[7:0] !== ref_mem[0][8'h10]) begin n_fail++; $display("FAIL start_no_gnt_mem: got %h want %h", rb[7:0], ref_mem[0][8'h10]); end
  endtask

  task automatic test_back_to_back();
    int gl;
    set_in(1'b0, 1'b1, 1'b0, 2'b00, 8'h10);
    gl = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) begin gl = i; break; end
    end
    set_in(1'b0, 1'b1, 1'b1, 2'b00, 8'h10);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) set_in(1'b0, 1'b1, 1'b0, 2'b00, 8'h10);
      if (c == 3) begin
        n_checks++;
        if (gl != 1 || rdy !== 1'b1 || gnt !== 1'b0 || rdata !== ref_mem[0][8'h10]) begin
          n_fail++; $display("FAIL b2b_end: gl %0d rdy %b gnt %b rdata %h want 1/1/0/%h", gl, rdy, gnt, rdata, ref_mem[0][8'h10]);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (gnt !== 1'b1 || rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_regrant: gnt %b rdy %b want 1/0", gnt, rdy); end
      end
    end
    exp_rd[0] += 1;
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random(input bit z, input int iters);
    logic [31:0] rb, wb; int n, bt, gl, nb;
    logic [7:0] a;
    logic [1:0] m;
    for (int it = 0; it < iters; it++) begin
      m  = z ? 2'b11 : {1'($urandom_range(0, 1)), 1'b1};
      nb = m[1] ? 4 : 1;
      a  = 8'($urandom);
      wb = $urandom;
      do_xfer(z, m, a, wb, rb, n, bt, gl);
      model_wr(z, a, wb, nb);
      n_checks++;
      if (bt != 0 || n != nb || gl != 1) begin
        n_fail++; $display("FAIL rnd_write_timing dut%0d it%0d: errs %0d beats %0d gl %0d want 0/%0d/1", z, it, bt, n, gl, nb);
      end
      do_xfer(z, {m[1], 1'b0}, a, 32'h0, rb, n, bt, gl);
      exp_rd[z] += nb;
      n_checks++;
      if (bt != 0 || n != nb) begin
        n_fail++; $display("FAIL rnd_read_timing dut%0d it%0d: errs %0d beats %0d want 0/%0d", z, it, bt, n, nb);
      end
      for (int i = 0; i < nb; i++) begin
        logic [7:0] ad;
        ad = a + 8'(i);
        n_checks++;
        if (rb[8*i +: 8] !== ref_mem[z][ad]) begin
          n_fail++; $display("FAIL rnd_read_data dut%0d mem[%h]: got %h want %h", z, ad, rb[8*i +: 8], ref_mem[z][ad]);
        end
      end
    end
  endtask

`ifdef BUS_ACCESS_COUNT_EN
  task automatic test_counters();
    n_checks++;
    if (rd_count !== 16'(exp_rd[0])) begin n_fail++; $display("FAIL rd_count: got %0d want %0d", rd_count, exp_rd[0]); end
    n_checks++;
    if (wr_count !== 16'(exp_wr[0])) begin n_fail++; $display("FAIL wr_count: got %0d want %0d", wr_count, exp_wr[0]); end
    n_checks++;
    if (z_rd_count !== 16'(exp_rd[1])) begin n_fail++; $display("FAIL z_rd_count: got %0d want %0d", z_rd_count, exp_rd[1]); end
    n_checks++;
    if (z_wr_count !== 16'(exp_wr[1])) begin n_fail++; $display("FAIL z_wr_count: got %0d want %0d", z_wr_count, exp_wr[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst_wrap();
    test_reset_mid();
    test_req_no_start();
    test_start_no_gnt();
    test_back_to_back();
    test_random(1'b0, 6);
    test_random(1'b1, 4);
`ifdef BUS_ACCESS_COUNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
